mcs51_uart: RTL

- Serial-port peripheral for the mcs51 core, implementing the standard 8051 mode-1 UART: 8 data bits, 1 start bit, 1 stop bit, variable baud.
- Sits on the core's internal SFR bus next to the port block; instantiated inside mcs51_mcu, with txd/rxd muxed onto P3.1/P3.0.
- Consumes SFR writes from the core; produces receive data, status flags and the serial interrupt request back to the core.

---
 rtl/mcs51_pkg.sv | 28 ++
 rtl/mcs51_uart_rx.sv | 147 ++++++++++++++
 rtl/mcs51_uart.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mcs51_pkg.sv
// Shared mcs51 definitions: SFR addresses, SCON bit positions and the UART
// frame state used by both the transmitter and the receiver.
package mcs51_pkg;

    localparam logic [7:0] SFR_SCON = 8'h98;
    localparam logic [7:0] SFR_SBUF = 8'h99;

    localparam int SCON_RI  = 0;
    localparam int SCON_TI  = 1;
    localparam int SCON_RB8 = 2;
    localparam int SCON_TB8 = 3;
    localparam int SCON_REN = 4;
    localparam int SCON_SM2 = 5;
    localparam int SCON_SM1 = 6;
    localparam int SCON_SM0 = 7;

    typedef enum logic [1:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } uart_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/mcs51_uart_rx.sv
// mcs51 UART receiver: rxd synchronizer, 3-sample majority voter and frame FSM.
// MCS51_UART_RXFIFO_EN adds a 4-entry receive FIFO popped by SBUF reads.
module mcs51_uart_rx
    import mcs51_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       rxd,
    input  logic       ren,
`ifdef MCS51_UART_RXFIFO_EN
    input  logic       pop,
`endif
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_stop
);

    uart_state_e state_q, state_d;

    logic [1:0] sync_q;
    logic       rxs;
    logic       rxs_d;
    logic       fall;
    logic [3:0] tcnt_q;
    logic [2:0] bcnt_q;
    logic [7:0] shift_q;
    logic [1:0] samp_q;
    logic       vote;
    logic       frame_done;

    assign rxs  = sync_q[1];
    assign fall = rxs_d & ~rxs;
    assign vote = maj3(samp_q[0], samp_q[1], rxs);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
            rxs_d  <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], rxd};
            rxs_d  <= rxs;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= U_IDLE;
        else          state_q <= state_d;
    end

    // Bits are voted on ticks 7/8/9; the bit boundary is tick 15.
    always_comb begin
        state_d = state_q;
        if (!ren) begin
            state_d = U_IDLE;
        end else begin
            unique case (state_q)
                U_IDLE: begin
                    if (fall) state_d = U_START;
                end
                U_START: begin
                    if (tick && tcnt_q == 4'd9 && vote)
                        state_d = U_IDLE;
                    else if (tick && tcnt_q == 4'd15)
                        state_d = U_DATA;
                end
                U_DATA: begin
                    if (tick && tcnt_q == 4'd15 && bcnt_q == 3'd7)
                        state_d = U_STOP;
                end
                U_STOP: begin
                    if (tick && tcnt_q == 4'd9) state_d = U_IDLE;
                end
                default: state_d = U_IDLE;
            endcase
        end
    end

    assign frame_done = ren && state_q == U_STOP
                      && tick && tcnt_q == 4'd9;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt_q  <= 4'd0;
            bcnt_q  <= 3'd0;
            shift_q <= 8'h00;
            samp_q  <= 2'b11;
        end else if (state_q == U_IDLE) begin
            tcnt_q <= 4'd0;
            bcnt_q <= 3'd0;
        end else if (tick) begin
            tcnt_q <= tcnt_q + 4'd1;
            if (tcnt_q == 4'd7) samp_q[0] <= rxs;
            if (tcnt_q == 4'd8) samp_q[1] <= rxs;
            if (state_q == U_DATA && tcnt_q == 4'd9)
                shift_q <= {vote, shift_q[7:1]};
            if (state_q == U_DATA && tcnt_q == 4'd15)
                bcnt_q <= bcnt_q + 3'd1;
        end
    end

`ifdef MCS51_UART_RXFIFO_EN
    logic [8:0] fifo_mem [4];
    logic [1:0] wr_ptr_q;
    logic [1:0] rd_ptr_q;
    logic [2:0] count_q;
    logic [7:0] last_q;
    logic       push;
    logic       pop_ok;

    assign push   = frame_done && count_q != 3'd4;
    assign pop_ok = pop && count_q != 3'd0;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {vote, shift_q};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            last_q   <= 8'h00;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
                last_q   <= fifo_mem[rd_ptr_q][7:0];
            end
            unique case ({push, pop_ok})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rx_valid = count_q != 3'd0;
    assign rx_data  = rx_valid ? fifo_mem[rd_ptr_q][7:0] : last_q;
    assign rx_stop  = rx_valid & fifo_mem[rd_ptr_q][8];
`else
    assign rx_valid = frame_done;
    assign rx_data  = shift_q;
    assign rx_stop  = vote;
`endif

endmodule

// File: rtl/mcs51_uart.sv
// mcs51 mode-1 serial port: tick divider, transmitter and SCON/SBUF decode.
// Define MCS51_UART_RXFIFO_EN for the 4-entry receive FIFO variant.
module mcs51_uart
    import mcs51_pkg::*;
#(
    parameter int         TICK_DIV  = 1,
    parameter logic [7:0] SCON_ADDR = SFR_SCON,
    parameter logic [7:0] SBUF_ADDR = SFR_SBUF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] sfr_addr,
    input  logic [7:0] sfr_wdata,
    input  logic       sfr_we,
    input  logic       sfr_re,
    output logic [7:0] sfr_rdata,
    output logic       sfr_hit,
    input  logic       rxd,
    output logic       txd,
    output logic       irq
);

    logic [15:0] div_q;
    logic        tick;

    assign tick = div_q == 16'(TICK_DIV - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  div_q <= 16'd0;
        else if (tick) div_q <= 16'd0;
        else           div_q <= div_q + 16'd1;
    end

    logic hit_scon;
    logic hit_sbuf;
    logic scon_we;
    logic sbuf_we;

    assign hit_scon = sfr_addr == SCON_ADDR;
    assign hit_sbuf = sfr_addr == SBUF_ADDR;
    assign sfr_hit  = hit_scon | hit_sbuf;
    assign scon_we  = sfr_we & hit_scon;
    assign sbuf_we  = sfr_we & hit_sbuf;

    uart_state_e tx_state_q, tx_state_d;

    logic       pend_q;
    logic [3:0] tx_tcnt_q;
    logic [2:0] tx_bcnt_q;
    logic [7:0] tx_shift_q;
    logic       tx_accept;
    logic       ti_set;

    // A byte waits in pend_q until the next tick so START is a full bit.
    assign tx_accept = sbuf_we && tx_state_q == U_IDLE && !pend_q;
    assign ti_set    = tx_state_q == U_DATA && tick
                     && tx_tcnt_q == 4'd15 && tx_bcnt_q == 3'd7;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tx_state_q <= U_IDLE;
        else          tx_state_q <= tx_state_d;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        unique case (tx_state_q)
            U_IDLE: begin
                if (pend_q && tick) tx_state_d = U_START;
            end
            U_START: begin
                if (tick && tx_tcnt_q == 4'd15) tx_state_d = U_DATA;
            end
            U_DATA: begin
                if (ti_set) tx_state_d = U_STOP;
            end
            U_STOP: begin
                if (tick && tx_tcnt_q == 4'd15) tx_state_d = U_IDLE;
            end
            default: tx_state_d = U_IDLE;
        endcase
    end

    always_comb begin
        txd = 1'b1;
        unique case (tx_state_q)
            U_START: txd = 1'b0;
            U_DATA:  txd = tx_shift_q[0];
            default: txd = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q     <= 1'b0;
            tx_tcnt_q  <= 4'd0;
            tx_bcnt_q  <= 3'd0;
            tx_shift_q <= 8'h00;
        end else if (tx_state_q == U_IDLE) begin
            tx_tcnt_q <= 4'd0;
            tx_bcnt_q <= 3'd0;
            if (tx_accept) begin
                pend_q     <= 1'b1;
                tx_shift_q <= sfr_wdata;
            end else if (tick) begin
                pend_q <= 1'b0;
            end
        end else if (tick) begin
            tx_tcnt_q <= tx_tcnt_q + 4'd1;
            if (tx_state_q == U_DATA && tx_tcnt_q == 4'd15) begin
                tx_shift_q <= {1'b1, tx_shift_q[7:1]};
                tx_bcnt_q  <= tx_bcnt_q + 3'd1;
            end
        end
    end

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_stop;
    logic [7:0] scon_q, scon_d;

    mcs51_uart_rx u_rx (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick     (tick),
        .rxd      (rxd),
        .ren      (scon_q[SCON_REN]),
`ifdef MCS51_UART_RXFIFO_EN
        .pop      (sfr_re & hit_sbuf),
`endif
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_stop  (rx_stop)
    );

`ifdef MCS51_UART_RXFIFO_EN
    logic [7:0] sbuf_rd;

    assign sbuf_rd = rx_data;

    // Software may clear RI, but a non-empty FIFO raises it again next clock.
    always_comb begin
        scon_d = scon_q;
        if (scon_we) scon_d = sfr_wdata;
        if (ti_set)  scon_d[SCON_TI] = 1'b1;
        if (rx_valid) begin
            scon_d[SCON_RB8] = rx_stop;
            if (!scon_we) scon_d[SCON_RI] = 1'b1;
        end
    end
`else
    logic [7:0] rxbuf_q;
    logic [7:0] sbuf_rd;
    logic       rx_load;
    logic       unused_re;

    assign unused_re = sfr_re;
    assign sbuf_rd   = rxbuf_q;
    // An unread byte (RI still set) makes the new frame an overrun.
    assign rx_load   = rx_valid & ~scon_q[SCON_RI];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     rxbuf_q <= 8'h00;
        else if (rx_load) rxbuf_q <= rx_data;
    end

    always_comb begin
        scon_d = scon_q;
        if (scon_we) scon_d = sfr_wdata;
        if (ti_set)  scon_d[SCON_TI] = 1'b1;
        if (rx_load) begin
            scon_d[SCON_RI]  = 1'b1;
            scon_d[SCON_RB8] = rx_stop;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) scon_q <= 8'h00;
        else          scon_q <= scon_d;
    end

    assign irq = scon_q[SCON_TI] | scon_q[SCON_RI];

    always_comb begin
        sfr_rdata = 8'h00;
        unique case (1'b1)
            hit_scon: sfr_rdata = scon_q;
            hit_sbuf: sfr_rdata = sbuf_rd;
            default:  sfr_rdata = 8'h00;
        endcase
    end

endmodule
